// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between an instruction and a data requester.
// Data wins arbitration unless DSTREAK consecutive data grants have starved a pending fetch.
module mem_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int DSTREAK = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        merr,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic        ram_ready,
  input  logic [31:0] ramload
);

  localparam int SW = $clog2(DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK);
  localparam logic [7:0]    WAIT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;

  state_t        r_state, w_state_next;
  logic [SW-1:0] r_streak, w_streak_next;
  logic [7:0]    r_wait;
  logic          r_err;
  logic          r_write;
  logic          r_owner_d;
  logic [31:0]   r_addr, r_store, r_iload, r_dload;

  logic w_force_i, w_grant_d, w_grant_i, w_busy, w_timeout;

  always_comb begin
    w_force_i = iREN && (r_streak == STREAK_MAX);
    w_grant_d = (r_state == IDLE) && (dREN || dWEN) && !w_force_i;
    w_grant_i = (r_state == IDLE) && iREN && !w_grant_d;
    w_busy    = (r_state == IBUSY) || (r_state == DBUSY);
    w_timeout = w_busy && !ram_ready && (r_wait == WAIT_LAST);

    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d)      w_state_next = DBUSY;
        else if (w_grant_i) w_state_next = IBUSY;
      end
      IBUSY, DBUSY: begin
        if (ram_ready || w_timeout) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    // Streak only grows while a fetch is actually waiting behind data traffic.
    w_streak_next = r_streak;
    if (w_grant_i) begin
      w_streak_next = '0;
    end else if (w_grant_d) begin
      if (!iREN)                     w_streak_next = '0;
      else if (r_streak != STREAK_MAX) w_streak_next = r_streak + SW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_streak  <= '0;
      r_wait    <= '0;
      r_err     <= 1'b0;
      r_write   <= 1'b0;
      r_owner_d <= 1'b0;
      r_addr    <= '0;
      r_store   <= '0;
      r_iload   <= '0;
      r_dload   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_streak <= w_streak_next;
      if (w_grant_d) begin
        r_addr    <= daddr;
        r_store   <= dstore;
        r_write   <= dWEN;
        r_owner_d <= 1'b1;
        r_wait    <= '0;
        r_err     <= 1'b0;
      end else if (w_grant_i) begin
        r_addr    <= iaddr;
        r_write   <= 1'b0;
        r_owner_d <= 1'b0;
        r_wait    <= '0;
        r_err     <= 1'b0;
      end else if (w_busy) begin
        if (ram_ready) begin
          if (!r_owner_d)    r_iload <= ramload;
          else if (!r_write) r_dload <= ramload;
        end else if (w_timeout) begin
          // An aborted access returns zero so stale data is never mistaken for a result.
          r_err <= 1'b1;
          if (r_owner_d) r_dload <= '0;
          else           r_iload <= '0;
        end else begin
          r_wait <= r_wait + 8'd1;
        end
      end
    end
  end

  assign ihit     = (r_state == DONE) && !r_owner_d;
  assign dhit     = (r_state == DONE) && r_owner_d;
  assign merr     = (r_state == DONE) && r_err;
  assign ramREN   = (r_state == IBUSY) || ((r_state == DBUSY) && !r_write);
  assign ramWEN   = (r_state == DBUSY) && r_write;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign iload    = r_iload;
  assign dload    = r_dload;

endmodule
